// File: rtl/rr_arb_pkg.sv
// Shared encodings for the round-robin arbiter and its 4:1 data mux.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Mux select convention {s1,s2}, s1 is the MSB.
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4_dw.sv
// Parameterised DW-wide combinational 4:1 mux.
module mux4_dw
  import rr_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [1:0]    sel,
  output logic [DW-1:0] y
);

  // Route the selected input to the output.
  always_comb begin
    case (sel)
      SEL_A:   y = d0;
      SEL_B:   y = d1;
      SEL_C:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_mux4.sv
// Round-robin arbiter sharing one 4:1 data mux between four streaming
// sources. A grant lasts up to MAX_HOLD transferred beats, or until the
// granted source drops its request, and is always followed by one idle cycle.
module rr_arbiter_mux4
  import rr_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  input  logic [DW-1:0] din_d,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] dout,
  output logic [3:0]    gnt,
  output logic [1:0]    sel
);

  arb_state_t    state;
  logic [1:0]    ptr;
  logic [CW-1:0] beat_cnt;
  logic [1:0]    pick;
  logic          found;
  logic          req_sel;
  logic          transfer;
  logic          last_beat;
  logic [DW-1:0] mux_y;

  // First requesting source found when searching from ptr upward, wrapping at 4.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        pick  = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

  // Handshake qualifiers derived from the registered select.
  always_comb begin
    req_sel   = req[sel];
    out_valid = (state == ST_BUSY) && req_sel;
    transfer  = out_valid && out_ready;
    last_beat = (beat_cnt == CW'(MAX_HOLD - 1));
  end

  mux4_dw #(
    .DW(DW)
  ) u_mux (
    .d0 (din_a),
    .d1 (din_b),
    .d2 (din_c),
    .d3 (din_d),
    .sel(sel),
    .y  (mux_y)
  );

  // Output data is forced to zero whenever no valid beat is presented.
  always_comb begin
    dout = out_valid ? mux_y : '0;
  end

  // Arbiter FSM: grant on a request from IDLE, release on drop or burst end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= SEL_A;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt      <= 4'(4'b0001 << pick);
            sel      <= pick;
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        default: begin
          if (!req_sel || (transfer && last_beat)) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            ptr      <= sel + 2'd1;
            beat_cnt <= '0;
          end else if (transfer) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_mux4.sv
// Self-checking bench for rr_arbiter_mux4: directed vector table,
// hand-written multi-cycle sequences and a randomised run against a
// behavioural round-robin model.
module tb_rr_arbiter_mux4;

  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
  localparam int CW       = 3;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] din_a, din_b, din_c, din_d;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic [3:0]    gnt;
  logic [1:0]    sel;

  int n_checks;
  int n_fail;

  // Behavioural model state: who holds the grant, how many beats so far,
  // where the next search starts, and the last select driven.
  int         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_beats;
  logic [1:0] m_sel;

  typedef struct {
    logic [3:0]    req;
    logic          rdy;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          ov;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[10];

  rr_arbiter_mux4 #(
    .DW(DW),
    .MAX_HOLD(MAX_HOLD),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .din_a    (din_a),
    .din_b    (din_b),
    .din_c    (din_c),
    .din_d    (din_d),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .dout     (dout),
    .gnt      (gnt),
    .sel      (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rdy,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [DW-1:0] d);
    req       = r;
    out_ready = rdy;
    din_a     = a;
    din_b     = b;
    din_c     = c;
    din_d     = d;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eg,
                             input logic [1:0] es, input logic eov,
                             input logic [DW-1:0] ed);
    n_checks++;
    if (gnt !== eg) begin
      n_fail++;
      $display("[TB] FAIL %s gnt: got %b expected %b", tag, gnt, eg);
    end
    n_checks++;
    if (sel !== es) begin
      n_fail++;
      $display("[TB] FAIL %s sel: got %b expected %b", tag, sel, es);
    end
    n_checks++;
    if (out_valid !== eov) begin
      n_fail++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, eov);
    end
    n_checks++;
    if (dout !== ed) begin
      n_fail++;
      $display("[TB] FAIL %s dout: got %h expected %h", tag, dout, ed);
    end
  endtask

  function automatic logic [DW-1:0] dinOf(input int idx);
    case (idx)
      0:       return din_a;
      1:       return din_b;
      2:       return din_c;
      default: return din_d;
    endcase
  endfunction

  task automatic modelReset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_beats = 0;
    m_sel   = 2'b00;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    int cand;
    if (m_busy == 0) begin
      if (req != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          cand = (m_ptr + 3 - i) % 4;
          if (req[cand]) m_owner = cand;
        end
        m_busy  = 1;
        m_sel   = 2'(m_owner);
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 4;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == MAX_HOLD) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
      end
    end
  endtask

  task automatic modelCheck(input string tag);
    logic [3:0]    eg;
    logic          ev;
    logic [DW-1:0] ed;
    eg = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
    ev = (m_busy != 0) && req[m_owner];
    ed = ev ? dinOf(m_owner) : '0;
    checkOutput(tag, eg, m_sel, ev, ed);
  endtask

  // Reset with all inputs idle; returns 1 time unit after a clock edge in IDLE.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, '0, '0, '0, '0);
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] dv[4];
    logic [3:0]    rq;
    logic [3:0]    eg;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    applyStimulus(4'b0000, 1'b0, '0, '0, '0, '0);
    modelReset();

    dv[0] = 8'h11;
    dv[1] = 8'h22;
    dv[2] = 8'h5A;
    dv[3] = 8'hDD;

    tbl[0] = '{4'b0100, 1'b1, 4'b0000, 2'b00, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 1'b1, 4'b0100, 2'b10, 1'b1, 8'h5A};
    tbl[2] = '{4'b0000, 1'b1, 4'b0100, 2'b10, 1'b0, 8'h00};
    tbl[3] = '{4'b1001, 1'b1, 4'b0000, 2'b10, 1'b0, 8'h00};
    tbl[4] = '{4'b1001, 1'b0, 4'b1000, 2'b11, 1'b1, 8'hDD};
    tbl[5] = '{4'b1001, 1'b1, 4'b1000, 2'b11, 1'b1, 8'hDD};
    tbl[6] = '{4'b1001, 1'b1, 4'b1000, 2'b11, 1'b1, 8'hDD};
    tbl[7] = '{4'b0001, 1'b1, 4'b1000, 2'b11, 1'b0, 8'h00};
    tbl[8] = '{4'b0001, 1'b1, 4'b0000, 2'b11, 1'b0, 8'h00};
    tbl[9] = '{4'b0001, 1'b1, 4'b0001, 2'b00, 1'b1, 8'h11};

    // Reset asserted with every source requesting: outputs stay quiet.
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(4'hF, 1'b1, dv[0], dv[1], dv[2], dv[3]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_active", 4'b0000, 2'b00, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_after", 4'b0000, 2'b00, 1'b0, 8'h00);
    applyStimulus(4'h0, 1'b1, dv[0], dv[1], dv[2], dv[3]);
    @(posedge clk);
    #1;

    // Directed table: single grant, drop release, pointer wrap from d to a.
    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].req, tbl[i].rdy, dv[0], dv[1], dv[2], dv[3]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].ov, tbl[i].dout);
      @(posedge clk);
      #1;
    end

    // All sources requesting: a,b,c,d,a with MAX_HOLD beats and one idle cycle each.
    $display("[TB] full-load rotation");
    doReset();
    for (int k = 0; k < 22; k++) begin
      applyStimulus(4'hF, 1'b1, dv[0], dv[1], dv[2], dv[3]);
      @(negedge clk);
      if (k % (MAX_HOLD + 1) == 0) begin
        eg = 4'b0000;
        n_checks++;
        if (gnt !== eg || out_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rot%0d idle: got gnt=%b valid=%b expected gnt=%b valid=0",
                   k, gnt, out_valid, eg);
        end
      end else begin
        eg = 4'(1 << ((k / (MAX_HOLD + 1)) % 4));
        checkOutput($sformatf("rot%0d", k), eg, 2'((k / (MAX_HOLD + 1)) % 4), 1'b1,
                    dv[(k / (MAX_HOLD + 1)) % 4]);
      end
      @(posedge clk);
      #1;
    end

    // Backpressure on b for ten cycles, then exactly MAX_HOLD beats complete.
    $display("[TB] backpressure hold");
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(4'b0010, (k >= 11) ? 1'b1 : 1'b0, dv[0], dv[1], dv[2], dv[3]);
      @(negedge clk);
      if (k == 0 || k == 15)
        checkOutput($sformatf("bp%0d", k), 4'b0000, (k == 0) ? 2'b00 : 2'b01, 1'b0, 8'h00);
      else
        checkOutput($sformatf("bp%0d", k), 4'b0010, 2'b01, 1'b1, dv[1]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset taken between edges while a grant is held.
    $display("[TB] async reset mid-burst");
    doReset();
    applyStimulus(4'b0001, 1'b0, dv[0], dv[1], dv[2], dv[3]);
    @(posedge clk);
    @(negedge clk);
    checkOutput("arst_busy", 4'b0001, 2'b00, 1'b1, dv[0]);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_low", 4'b0000, 2'b00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic with slowly changing requests against the model.
    $display("[TB] randomised run");
    doReset();
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      applyStimulus(rq, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                    DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      @(negedge clk);
      modelCheck($sformatf("rand%0d", n));
      @(posedge clk);
      modelStep();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
